pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width in bits, legal range 1..512.
REQ-002 SHALL have parameter SKID, default 1: 1 = two-entry skid stage with registered in_ready; 0 = single-entry stage with combinational in_ready.
REQ-003 SHALL have parameter RST_DATA, default all-zero (DATA_W bits): payload value loaded at reset and on flush.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream holds a valid payload.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_data  output  DATA_W  head payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-012 SHALL have port stall  input  1  hazard hold; freezes the output side.
REQ-013 SHALL have port flush  input  1  squash all held entries (branch/trap kill).
REQ-014 SHALL have port occupancy  output  2  number of held entries (0..2 when SKID=1, 0..1 when SKID=0).

Function
REQ-015 SHALL define accept = in_valid & in_ready, and pop = out_valid & out_ready & ~stall.
REQ-016 SHALL keep out_data and out_valid bit-stable while out_valid=1 and pop=0.
REQ-017 SHALL, with SKID=1, hold entries main and skid; out_data = main data; out_valid = main valid.
REQ-018 SHALL, with SKID=1, drive in_ready = ~skid_valid directly from a flop, with no combinational path from out_ready or stall.
REQ-019 SHALL, with SKID=1, move through the following states on each edge:
- EMPTY + accept -> ONE, data into main.
- ONE + accept + pop -> ONE, main <= in_data.
- ONE + accept + ~pop -> FULL, data into skid.
- ONE + pop + ~accept -> EMPTY.
- FULL + pop -> ONE, main <= skid.
- FULL has accept=0 by construction.
REQ-020 SHALL, with SKID=0, drive in_ready = ~out_valid | (out_ready & ~stall), and on accept load main in the same edge as any pop.
REQ-021 SHALL give a latency of exactly 1 cycle from accept to out_valid when the stage is empty.
REQ-022 SHALL preserve payload order, with no loss or duplication, under any in_valid/out_ready/stall pattern.
REQ-023 SHALL, on flush=1:
- clear all valid bits and load RST_DATA into data regs at the next edge;
- drop a simultaneous accept;
- make a simultaneous pop the only transfer of that cycle.
REQ-024 SHALL give flush priority over stall; stall has priority over out_ready.
REQ-025 SHALL drive occupancy from the valid flops only, with no combinational path from inputs.
REQ-026 SHALL treat in_data as don't-care when in_valid=0, and hold no X in state after reset.

Reset
REQ-027 SHALL, when nrst=0 at an edge, set: out_valid=0, all valid bits=0, occupancy=0, data regs=RST_DATA, in_ready=1 (both modes) from the next cycle.
REQ-028 SHALL let reset override flush, stall and accept; mid-transfer payloads are discarded.

Structure
REQ-029 SHALL place the occupancy encoding constants and a per-stage payload struct typedef (rs1, rs2, rd, pc, operands, mem_op, alu_op, wb_src, csr_op) in shared package pipe_pkg, so each stage instantiates pipe_stage_reg with DATA_W = $bits(struct).
REQ-030 SHALL be a single module with a generate branch on SKID and no sub-modules.

Verification
REQ-031 Bench SHALL cover, SKID=1, DATA_W=32: hold out_ready=1, send 0x11,0x22,0x33 back-to-back -> outputs 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its accept, occupancy stays at 1.
REQ-032 Bench SHALL cover, SKID=1: out_ready=0, send 0xA and 0xB -> occupancy=2, in_ready=0; then out_ready=1 -> 0xA then 0xB, with in_ready=1 one cycle after the first pop.
REQ-033 Bench SHALL cover: stall=1 with out_ready=1 and 0x5 held -> out_data=0x5 and out_valid=1 unchanged for 4 cycles, no pop; release stall -> pop of 0x5.
REQ-034 Bench SHALL cover: occupancy=2, flush=1 with in_valid=1 (0x77) -> next cycle out_valid=0, occupancy=0, out_data=RST_DATA, 0x77 never appears at the output.
REQ-035 Bench SHALL cover, SKID=0: out_valid=1, out_ready=1, in_valid=1 (0x9) -> in_ready=1 in the same cycle, 0x9 output next cycle.
REQ-036 Bench SHALL cover: nrst=0 during a FULL state -> next cycle occupancy=0, out_valid=0, in_ready=1; plus a random-traffic scoreboard check for order and no loss.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encodings, the per-stage payload
// struct carried between stages, and the occupancy encoder used by pipe_stage_reg.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef enum logic [2:0] {
        MEM_NONE,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4,
        WB_CSR
    } wb_src_e;

    typedef enum logic [1:0] {
        CSR_NONE,
        CSR_RW,
        CSR_RS,
        CSR_RC
    } csr_op_e;

    // Stages instantiate pipe_stage_reg with DATA_W = $bits(stage_payload_t).
    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [31:0]      pc;
        logic [1:0][31:0] operands;
        mem_op_e          mem_op;
        alu_op_e          alu_op;
        wb_src_e          wb_src;
        csr_op_e          csr_op;
    } stage_payload_t;

    localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

    // A skid entry only ever exists behind a valid main entry.
    function automatic logic [1:0] occ_encode(input logic main_v, input logic skid_v);
        if (main_v && skid_v) return OCC_FULL;
        if (main_v)           return OCC_ONE;
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with stall and flush. SKID=1 builds a two-entry
// skid stage with a registered in_ready; SKID=0 a single entry with pass-through ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                SKID     = 1,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              pop;

    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready & ~stall;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;

            // Ready depends only on the skid flop, breaking the out_ready/stall path.
            assign in_ready  = ~skid_valid;
            assign occupancy = occ_encode(main_valid, skid_valid);

            always_ff @(posedge clk) begin
                // NOTE: data regs are reset as well, so reset/flush leave no X in state
                // and out_data shows RST_DATA whenever the stage has been cleared.
                if (!nrst || flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_data  <= RST_DATA;
                    skid_data  <= RST_DATA;
                end else begin
                    case ({main_valid, skid_valid})
                        2'b00: begin
                            if (accept) begin
                                main_data  <= in_data;
                                main_valid <= 1'b1;
                            end
                        end
                        2'b10: begin
                            if (accept && pop) begin
                                main_data <= in_data;
                            end else if (accept) begin
                                skid_data  <= in_data;
                                skid_valid <= 1'b1;
                            end else if (pop) begin
                                main_valid <= 1'b0;
                            end
                        end
                        2'b11: begin
                            if (pop) begin
                                main_data  <= skid_data;
                                skid_valid <= 1'b0;
                            end
                        end
                        default: begin
                            main_valid <= 1'b0;
                            skid_valid <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready  = ~main_valid | (out_ready & ~stall);
            assign occupancy = occ_encode(main_valid, 1'b0);

            always_ff @(posedge clk) begin
                if (!nrst || flush) begin
                    main_valid <= 1'b0;
                    main_data  <= RST_DATA;
                end else if (accept) begin
                    main_data  <= in_data;
                    main_valid <= 1'b1;
                end else if (pop) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-entry instance,
// directed scenarios plus random traffic checked against per-instance scoreboards.
module tb_pipe_stage_reg;

    localparam int          W       = 32;
    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic nrst;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stall, s_flush;
    logic [W-1:0]  s_in_data, s_out_data;
    logic [1:0]    s_occ;

    logic          f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_stall, f_flush;
    logic [W-1:0]  f_in_data, f_out_data;
    logic [1:0]    f_occ;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] s_q[$];
    logic [W-1:0] f_q[$];

    pipe_stage_reg #(.DATA_W(W), .SKID(1), .RST_DATA(RST_VAL)) u_skid (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .stall     (s_stall),
        .flush     (s_flush),
        .occupancy (s_occ)
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(0)) u_single (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (f_in_valid),
        .in_data   (f_in_data),
        .in_ready  (f_in_ready),
        .out_valid (f_out_valid),
        .out_data  (f_out_data),
        .out_ready (f_out_ready),
        .stall     (f_stall),
        .flush     (f_flush),
        .occupancy (f_occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards sample mid-cycle: pop first, then flush/reset clears, then accept pushes.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (!nrst) begin
            s_q.delete();
        end else begin
            if (s_out_valid && s_out_ready && !s_stall) begin
                check("s_sb_nonempty", {31'b0, s_q.size() != 0}, 32'd1);
                if (s_q.size() != 0) begin
                    exp_v = s_q.pop_front();
                    check("s_sb_order", s_out_data, exp_v);
                end
            end
            if (s_flush) s_q.delete();
            else if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (!nrst) begin
            f_q.delete();
        end else begin
            if (f_out_valid && f_out_ready && !f_stall) begin
                check("f_sb_nonempty", {31'b0, f_q.size() != 0}, 32'd1);
                if (f_q.size() != 0) begin
                    exp_v = f_q.pop_front();
                    check("f_sb_order", f_out_data, exp_v);
                end
            end
            if (f_flush) f_q.delete();
            else if (f_in_valid && f_in_ready) f_q.push_back(f_in_data);
        end
    end

    initial begin
        logic [W-1:0] seq [3];
        seq = '{32'h11, 32'h22, 32'h33};

        nrst = 1'b0;
        s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_stall = 0; s_flush = 0;
        f_in_valid = 0; f_in_data = '0; f_out_ready = 0; f_stall = 0; f_flush = 0;
        tick();
        tick();
        nrst = 1'b1;

        check("rst_s_out_valid", {31'b0, s_out_valid}, 32'd0);
        check("rst_s_occ",       {30'b0, s_occ},       32'd0);
        check("rst_s_in_ready",  {31'b0, s_in_ready},  32'd1);
        check("rst_s_out_data",  s_out_data,           RST_VAL);
        check("rst_f_out_valid", {31'b0, f_out_valid}, 32'd0);
        check("rst_f_occ",       {30'b0, f_occ},       32'd0);
        check("rst_f_in_ready",  {31'b0, f_in_ready},  32'd1);
        check("rst_f_out_data",  f_out_data,           32'd0);

        // Back-to-back streaming with out_ready held high.
        s_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1;
            s_in_data  = seq[i];
            tick();
            check("bb_out_valid", {31'b0, s_out_valid}, 32'd1);
            check("bb_out_data",  s_out_data,           seq[i]);
            check("bb_occ",       {30'b0, s_occ},       32'd1);
        end
        s_in_valid = 0;
        tick();
        check("bb_drained", {31'b0, s_out_valid}, 32'd0);

        // Fill both entries, then drain in order.
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'hA;
        tick();
        s_in_data = 32'hB;
        tick();
        check("full_occ",      {30'b0, s_occ},      32'd2);
        check("full_in_ready", {31'b0, s_in_ready}, 32'd0);
        check("full_head",     s_out_data,          32'hA);
        s_in_valid = 0; s_out_ready = 1;
        tick();
        check("drain_first",    s_out_data,          32'hB);
        check("drain_in_ready", {31'b0, s_in_ready}, 32'd1);
        check("drain_occ",      {30'b0, s_occ},      32'd1);
        tick();
        check("drain_empty", {31'b0, s_out_valid}, 32'd0);

        // Stall holds the head stable despite out_ready.
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'h5;
        tick();
        s_in_valid = 0; s_stall = 1; s_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", {31'b0, s_out_valid}, 32'd1);
            check("stall_data",  s_out_data,           32'h5);
        end
        s_stall = 0;
        tick();
        check("stall_release", {31'b0, s_out_valid}, 32'd0);

        // Flush from FULL with a pending input.
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'h61;
        tick();
        s_in_data = 32'h62;
        tick();
        check("pre_flush_occ", {30'b0, s_occ}, 32'd2);
        s_flush = 1; s_in_data = 32'h77;
        tick();
        check("flush_valid", {31'b0, s_out_valid}, 32'd0);
        check("flush_occ",   {30'b0, s_occ},       32'd0);
        check("flush_data",  s_out_data,           RST_VAL);
        s_flush = 0; s_in_valid = 0;
        tick();
        check("flush_no_77", {31'b0, s_out_valid}, 32'd0);

        // Flush coinciding with a pop and an accept: only the pop transfers.
        s_out_ready = 1;
        s_in_valid = 1; s_in_data = 32'h41;
        tick();
        s_flush = 1; s_in_data = 32'h78;
        tick();
        check("flush_pop_valid", {31'b0, s_out_valid}, 32'd0);
        check("flush_pop_data",  s_out_data,           RST_VAL);
        s_flush = 0; s_in_valid = 0;

        // Single-entry: pass-through ready while the held entry leaves.
        f_out_ready = 0;
        f_in_valid = 1; f_in_data = 32'h8;
        tick();
        check("f_hold_data", f_out_data, 32'h8);
        f_out_ready = 1; f_in_data = 32'h9;
        #1;
        check("f_pass_ready", {31'b0, f_in_ready}, 32'd1);
        tick();
        check("f_next_valid", {31'b0, f_out_valid}, 32'd1);
        check("f_next_data",  f_out_data,           32'h9);
        f_out_ready = 0; f_in_data = 32'hA;
        #1;
        check("f_block_ready", {31'b0, f_in_ready}, 32'd0);
        f_stall = 1; f_out_ready = 1;
        #1;
        check("f_stall_ready", {31'b0, f_in_ready}, 32'd0);
        f_stall = 0; f_in_valid = 0;
        tick();
        check("f_empty", {31'b0, f_out_valid}, 32'd0);

        // Reset while FULL.
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'hC1;
        tick();
        s_in_data = 32'hC2;
        tick();
        check("rstfull_pre_occ", {30'b0, s_occ}, 32'd2);
        s_in_valid = 0;
        nrst = 0;
        tick();
        check("rstfull_occ",      {30'b0, s_occ},      32'd0);
        check("rstfull_valid",    {31'b0, s_out_valid}, 32'd0);
        check("rstfull_in_ready", {31'b0, s_in_ready},  32'd1);
        nrst = 1;

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            s_in_valid  = 1'($urandom_range(0, 1));
            s_in_data   = $urandom;
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_stall     = ($urandom_range(0, 7) == 0);
            s_flush     = ($urandom_range(0, 49) == 0);
            f_in_valid  = 1'($urandom_range(0, 1));
            f_in_data   = $urandom;
            f_out_ready = ($urandom_range(0, 3) != 0);
            f_stall     = ($urandom_range(0, 7) == 0);
            f_flush     = ($urandom_range(0, 49) == 0);
            tick();
            check("rand_s_occ", {30'b0, s_occ}, s_q.size());
            check("rand_f_occ", {30'b0, f_occ}, f_q.size());
        end

        s_in_valid = 0; s_out_ready = 1; s_stall = 0; s_flush = 0;
        f_in_valid = 0; f_out_ready = 1; f_stall = 0; f_flush = 0;
        for (int i = 0; i < 8 && (s_q.size() != 0 || f_q.size() != 0); i++) tick();
        check("drain_s_sb",    s_q.size(),           32'd0);
        check("drain_f_sb",    f_q.size(),           32'd0);
        check("drain_s_valid", {31'b0, s_out_valid}, 32'd0);
        check("drain_f_valid", {31'b0, f_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
